// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one partial product per clock.
// Operands are latched as magnitudes with a separate sign flag, so the core
// datapath is purely unsigned; the sign is applied when the result is stored.
//
// Handshake: start is sampled only in IDLE or DONE. When accepted, busy is high
// for exactly WIDTH cycles (RUN). The edge that ends RUN loads O and raises
// done for a single cycle. busy and done are never high together.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   signed_mode,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  output logic [2*WIDTH-1:0]     O,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]      mplier_q, mplier_d;
  logic [2*WIDTH:0]      acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic [2*WIDTH-1:0]    o_q, o_d;

  // Operand conditioning and one shift-add step, shared by the FSM below.
  logic [WIDTH-1:0]      mag_a, mag_b;
  logic                  neg_in;
  logic [WIDTH:0]        upper_sum;
  logic [2*WIDTH:0]      acc_step;
  logic [2*WIDTH-1:0]    prod;
  logic [2*WIDTH-1:0]    result;

  // Magnitudes, sign, next accumulator value and signed result.
  always_comb begin
    // The magnitude of the most negative value, 2^(WIDTH-1), still fits in WIDTH bits.
    mag_a     = (signed_mode && A[WIDTH-1]) ? -A : A;
    mag_b     = (signed_mode && B[WIDTH-1]) ? -B : B;
    neg_in    = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
    // The top accumulator bit catches the carry of the add before the shift.
    upper_sum = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_step  = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
    prod      = acc_step[2*WIDTH-1:0];
    result    = neg_q ? -prod : prod;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    o_d      = o_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = mag_a;
          mplier_d = mag_b;
          neg_d    = neg_in;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          o_d     = result;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      o_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      o_q      <= o_d;
    end
  end

  assign O    = o_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
